// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one external combinational ALU between two requesters. A round-robin
// arbiter accepts one operation at a time, drives the ALU for a single cycle,
// captures the result and holds it until the winning requester takes it.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   reqN_valid_i / reqN_ready_o   request handshake, N = 0, 1
//   reqN_a_i, reqN_b_i, reqN_sel_i operands and ALUsel encoding
//   rspN_valid_o / rspN_ready_i   response handshake, N = 0, 1
//   rsp_result_o, rsp_err_o       shared result; err flags an unsupported sel
//   alu_a_o, alu_b_o, alu_sel_o   to the ALU (zero outside the execute cycle)
//   alu_result_i                  from the ALU, combinational on the above
//
// Optional feature, enabled by defining ALU_ARB_STATS_EN:
//   stats_clr_i                   synchronous clear of the grant counters
//   gnt_cnt0_o, gnt_cnt1_o        saturating 16-bit per-requester grant counts
module alu_share_arbiter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid_i,
  output logic            req0_ready_o,
  input  logic [XLEN-1:0] req0_a_i,
  input  logic [XLEN-1:0] req0_b_i,
  input  logic [3:0]      req0_sel_i,
  input  logic            req1_valid_i,
  output logic            req1_ready_o,
  input  logic [XLEN-1:0] req1_a_i,
  input  logic [XLEN-1:0] req1_b_i,
  input  logic [3:0]      req1_sel_i,
  output logic            rsp0_valid_o,
  input  logic            rsp0_ready_i,
  output logic            rsp1_valid_o,
  input  logic            rsp1_ready_i,
  output logic [XLEN-1:0] rsp_result_o,
  output logic            rsp_err_o,
  output logic [XLEN-1:0] alu_a_o,
  output logic [XLEN-1:0] alu_b_o,
  output logic [3:0]      alu_sel_o,
`ifdef ALU_ARB_STATS_EN
  input  logic            stats_clr_i,
  output logic [15:0]     gnt_cnt0_o,
  output logic [15:0]     gnt_cnt1_o,
`endif
  input  logic [XLEN-1:0] alu_result_i
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e          state_q;
  logic            last_q;    // id of the most recent grant
  logic            gnt_id_q;  // id of the operation in flight
  logic [XLEN-1:0] op_a_q;
  logic [XLEN-1:0] op_b_q;
  logic [3:0]      op_sel_q;
  logic [XLEN-1:0] result_q;
  logic            err_q;

  logic            gnt0;
  logic            gnt1;
  logic            sel_ok;
  logic            rsp_take;

  function automatic logic sel_legal(input logic [3:0] sel);
    logic ok;
    case (sel)
      4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b0111,
      4'b1000, 4'b1001, 4'b1010, 4'b1101, 4'b1111: ok = 1'b1;
      default:                                     ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Arbitration only in idle. Gated by rst_n so ready drops as soon as reset
  // asserts, even with valid held high.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n && (state_q == StIdle)) begin
      if (req0_valid_i && (!req1_valid_i || last_q)) begin
        gnt0 = 1'b1;
      end else if (req1_valid_i) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign sel_ok   = sel_legal(op_sel_q);
  // Only the granted requester's ready can complete the response.
  assign rsp_take = gnt_id_q ? rsp1_ready_i : rsp0_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      last_q   <= 1'b1;
      gnt_id_q <= 1'b0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_sel_q <= 4'b0000;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (gnt0 || gnt1) begin
            op_a_q   <= gnt1 ? req1_a_i : req0_a_i;
            op_b_q   <= gnt1 ? req1_b_i : req0_b_i;
            op_sel_q <= gnt1 ? req1_sel_i : req0_sel_i;
            gnt_id_q <= gnt1;
            last_q   <= gnt1;
            state_q  <= StExec;
          end
        end
        StExec: begin
          result_q <= sel_ok ? alu_result_i : '0;
          err_q    <= ~sel_ok;
          state_q  <= StResp;
        end
        StResp: begin
          if (rsp_take) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req0_ready_o = gnt0;
  assign req1_ready_o = gnt1;
  assign rsp0_valid_o = (state_q == StResp) && !gnt_id_q;
  assign rsp1_valid_o = (state_q == StResp) && gnt_id_q;
  assign rsp_result_o = result_q;
  assign rsp_err_o    = err_q;

  // ALU inputs stay quiet except during the single execute cycle.
  assign alu_a_o   = (state_q == StExec) ? op_a_q : '0;
  assign alu_b_o   = (state_q == StExec) ? op_b_q : '0;
  assign alu_sel_o = ((state_q == StExec) && sel_ok) ? op_sel_q : 4'b0000;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] cnt0_q;
  logic [15:0] cnt1_q;

  // Clear wins over a same-cycle grant; counts saturate at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (stats_clr_i) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (gnt0 && (cnt0_q != 16'hFFFF)) begin
        cnt0_q <= cnt0_q + 16'd1;
      end
      if (gnt1 && (cnt1_q != 16'hFFFF)) begin
        cnt1_q <= cnt1_q + 16'd1;
      end
    end
  end

  assign gnt_cnt0_o = cnt0_q;
  assign gnt_cnt1_o = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: a behavioural ALU sits on the alu_* ports,
// a scoreboard records the expected result at each accepted request and is
// compared when the matching response handshakes.
`timescale 1ns/1ps
module tb_alu_share_arbiter;
  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req0_valid = 1'b0, req1_valid = 1'b0;
  logic            req0_ready, req1_ready;
  logic [XLEN-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]      req0_sel = '0, req1_sel = '0;
  logic            rsp0_valid, rsp1_valid;
  logic            rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [XLEN-1:0] rsp_result, alu_a, alu_b, alu_result;
  logic            rsp_err;
  logic [3:0]      alu_sel;
`ifdef ALU_ARB_STATS_EN
  logic            stats_clr = 1'b0;
  logic [15:0]     gnt_cnt0, gnt_cnt1;
`endif

  always #5 clk = ~clk;

  alu_share_arbiter #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid_i (req0_valid),
    .req0_ready_o (req0_ready),
    .req0_a_i     (req0_a),
    .req0_b_i     (req0_b),
    .req0_sel_i   (req0_sel),
    .req1_valid_i (req1_valid),
    .req1_ready_o (req1_ready),
    .req1_a_i     (req1_a),
    .req1_b_i     (req1_b),
    .req1_sel_i   (req1_sel),
    .rsp0_valid_o (rsp0_valid),
    .rsp0_ready_i (rsp0_ready),
    .rsp1_valid_o (rsp1_valid),
    .rsp1_ready_i (rsp1_ready),
    .rsp_result_o (rsp_result),
    .rsp_err_o    (rsp_err),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_sel_o    (alu_sel),
`ifdef ALU_ARB_STATS_EN
    .stats_clr_i  (stats_clr),
    .gnt_cnt0_o   (gnt_cnt0),
    .gnt_cnt1_o   (gnt_cnt1),
`endif
    .alu_result_i (alu_result)
  );

  // Reference: {err, result} for a requested operation.
  function automatic logic [XLEN:0] ref_alu(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                           input logic [3:0] sel);
    logic [XLEN-1:0] r;
    logic            e;
    e = 1'b0;
    case (sel)
      4'b0000: r = a + b;
      4'b0001: r = a - b;
      4'b0100: r = a | b;
      4'b0101: r = a & b;
      4'b0111: r = a ^ b;
      4'b1000: r = a << b[4:0];
      4'b1001: r = a >> b[4:0];
      4'b1010: r = $signed(a) >>> b[4:0];
      4'b1101: r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b1111: r = {{(XLEN-1){1'b0}}, (a < b)};
      default: begin r = '0; e = 1'b1; end
    endcase
    return {e, r};
  endfunction

  // Environment ALU; a garbage value on unsupported selects exposes leaks.
  function automatic logic [XLEN-1:0] env_alu(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                             input logic [3:0] sel);
    logic [XLEN:0] r;
    r = ref_alu(a, b, sel);
    return r[XLEN] ? 32'hDEAD_BEEF : r[XLEN-1:0];
  endfunction

  assign alu_result = env_alu(alu_a, alu_b, alu_sel);

  typedef struct packed {
    logic            id;
    logic [XLEN-1:0] res;
    logic            err;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_pass = 0;
  int   n_total = 0;

  // Values sampled on the falling edge by tick().
  logic            s_rdy0, s_rdy1, s_rv0, s_rv1, s_err, hs0, hs1;
  logic [XLEN-1:0] s_res, s_alu_a, s_alu_b;
  logic [3:0]      s_alu_sel;

  // One clock: sample at negedge, record accepted requests, then after the
  // rising edge drop the valid of whichever request was taken.
  task automatic tick();
    logic [XLEN:0] r;
    logic          acc0, acc1;
    exp_t          x;
    @(negedge clk);
    s_rdy0 = req0_ready; s_rdy1 = req1_ready;
    s_rv0 = rsp0_valid;  s_rv1 = rsp1_valid;
    s_res = rsp_result;  s_err = rsp_err;
    s_alu_a = alu_a; s_alu_b = alu_b; s_alu_sel = alu_sel;
    hs0 = rsp0_valid && rsp0_ready;
    hs1 = rsp1_valid && rsp1_ready;
    acc0 = req0_valid && req0_ready;
    acc1 = req1_valid && req1_ready;
    if (acc0) begin
      r = ref_alu(req0_a, req0_b, req0_sel);
      x.id = 1'b0; x.res = r[XLEN-1:0]; x.err = r[XLEN];
      sb.push_back(x);
    end
    if (acc1) begin
      r = ref_alu(req1_a, req1_b, req1_sel);
      x.id = 1'b1; x.res = r[XLEN-1:0]; x.err = r[XLEN];
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
    if (acc0) req0_valid = 1'b0;
    if (acc1) req1_valid = 1'b0;
  endtask

  task automatic set_req0(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [3:0] sel);
    req0_a = a; req0_b = b; req0_sel = sel; req0_valid = 1'b1;
  endtask

  task automatic set_req1(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [3:0] sel);
    req1_a = a; req1_b = b; req1_sel = sel; req1_valid = 1'b1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_req0(32'd1, 32'd2, 4'b0000);
    set_req1(32'd3, 32'd4, 4'b0000);
    #3;
    n_total++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000",
               {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err});
    else n_pass++;
    n_total++;
    if (rsp_result !== '0 || alu_a !== '0 || alu_b !== '0 || alu_sel !== 4'b0)
      $display("FAIL reset_data: got res=%h a=%h b=%h sel=%b want zeros",
               rsp_result, alu_a, alu_b, alu_sel);
    else n_pass++;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    n_total++;
    if ({s_rdy0, s_rdy1, s_rv0, s_rv1} !== 4'b0)
      $display("FAIL idle_no_valid: got %b want 0000", {s_rdy0, s_rdy1, s_rv0, s_rv1});
    else n_pass++;
  endtask

  task automatic test_single();
    rsp0_ready = 1'b1;
    set_req0(32'd5, 32'd7, 4'b0000);
    tick();
    n_total++;
    if ({s_rdy0, s_rdy1} !== 2'b10) $display("FAIL single_accept: got %b want 10", {s_rdy0, s_rdy1});
    else n_pass++;
    tick();
    n_total++;
    if (s_alu_sel !== 4'b0000 || s_alu_a !== 32'd5 || s_alu_b !== 32'd7 || s_rv0 !== 1'b0)
      $display("FAIL single_exec: got sel=%b a=%0d b=%0d rv=%b want 0000 5 7 0",
               s_alu_sel, s_alu_a, s_alu_b, s_rv0);
    else n_pass++;
    tick();
    n_total++;
    if (!hs0 || s_res !== 32'd12 || s_err !== 1'b0 || sb.size() != 1)
      $display("FAIL single_rsp: got hs=%b res=%0d err=%b sb=%0d want 1 12 0 1",
               hs0, s_res, s_err, sb.size());
    else begin
      e = sb.pop_front();
      if (e.id !== 1'b0 || e.res !== s_res || e.err !== s_err) $display("FAIL single_sb");
      else n_pass++;
    end
    tick();
    n_total++;
    if (s_rv0 !== 1'b0) $display("FAIL single_drop: got rv0=%b want 0", s_rv0);
    else n_pass++;
  endtask

  task automatic test_tie();
    int served;
    apply_reset();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    set_req0(32'd10, 32'd3, 4'b0001);
    set_req1(32'hF0, 32'h0F, 4'b0111);
    served = 0;
    for (int i = 0; i < 16 && served < 2; i++) begin
      tick();
      if (i == 0) begin
        n_total++;
        if ({s_rdy0, s_rdy1} !== 2'b10) $display("FAIL tie_first: got %b want 10", {s_rdy0, s_rdy1});
        else n_pass++;
      end
      if (hs0 || hs1) begin
        n_total++;
        if (sb.size() == 0) $display("FAIL tie_rsp: response with empty scoreboard");
        else begin
          e = sb.pop_front();
          // Fixed order: req0 SUB gives 7, then req1 XOR gives FF.
          if (e.id !== hs1 || e.res !== s_res || e.err !== s_err || hs1 !== (served == 1) ||
              s_res !== ((served == 0) ? 32'd7 : 32'hFF))
            $display("FAIL tie_rsp%0d: got id=%b res=%h err=%b want id=%b res=%h",
                     served, hs1, s_res, s_err, e.id, e.res);
          else n_pass++;
        end
        served++;
      end
    end
    n_total++;
    if (served != 2) $display("FAIL tie_timeout: got %0d responses want 2", served);
    else n_pass++;
    set_req0(32'd1, 32'd1, 4'b0000);
    set_req1(32'd2, 32'd2, 4'b0000);
    tick();
    n_total++;
    if ({s_rdy0, s_rdy1} !== 2'b10) $display("FAIL tie_second: got %b want 10", {s_rdy0, s_rdy1});
    else n_pass++;
    served = 0;
    for (int i = 0; i < 16 && served < 2; i++) begin
      tick();
      if (hs0 || hs1) begin
        n_total++;
        e = sb.pop_front();
        if (e.id !== hs1 || e.res !== s_res || e.err !== s_err)
          $display("FAIL tie2_rsp: got id=%b res=%h want id=%b res=%h", hs1, s_res, e.id, e.res);
        else n_pass++;
        served++;
      end
    end
  endtask

  task automatic test_backpressure();
    int served;
    rsp0_ready = 1'b1; rsp1_ready = 1'b0;
    set_req1(32'd1, 32'd2, 4'b1111);
    tick();
    n_total++;
    if (s_rdy1 !== 1'b1) $display("FAIL bp_accept: got rdy1=%b want 1", s_rdy1);
    else n_pass++;
    set_req0(32'd100, 32'd1, 4'b0000);
    tick();
    n_total++;
    if (s_rdy0 !== 1'b0 || s_alu_sel !== 4'b1111)
      $display("FAIL bp_exec: got rdy0=%b sel=%b want 0 1111", s_rdy0, s_alu_sel);
    else n_pass++;
    // rsp0_ready is high throughout: it must not release the req1 response.
    for (int i = 0; i < 5; i++) begin
      tick();
      n_total++;
      if (s_rv1 !== 1'b1 || s_rv0 !== 1'b0 || s_res !== 32'd1 || s_rdy0 !== 1'b0)
        $display("FAIL bp_hold%0d: got rv1=%b rv0=%b res=%h rdy0=%b want 1 0 1 0",
                 i, s_rv1, s_rv0, s_res, s_rdy0);
      else n_pass++;
    end
    rsp1_ready = 1'b1;
    tick();
    n_total++;
    e = sb.pop_front();
    if (!hs1 || e.id !== 1'b1 || e.res !== s_res || e.err !== s_err || s_rdy0 !== 1'b0)
      $display("FAIL bp_rsp: got hs1=%b res=%h rdy0=%b want 1 %h 0", hs1, s_res, s_rdy0, e.res);
    else n_pass++;
    tick();
    n_total++;
    if (s_rdy0 !== 1'b1) $display("FAIL bp_req0_after: got rdy0=%b want 1", s_rdy0);
    else n_pass++;
    served = 0;
    for (int i = 0; i < 8 && served < 1; i++) begin
      tick();
      if (hs0 || hs1) begin
        n_total++;
        e = sb.pop_front();
        if (e.id !== hs1 || e.res !== s_res || s_res !== 32'd101)
          $display("FAIL bp_req0_rsp: got res=%0d want 101", s_res);
        else n_pass++;
        served++;
      end
    end
  endtask

  task automatic test_unsupported();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    set_req0(32'd3, 32'd4, 4'b0010);
    tick();
    tick();
    n_total++;
    if (s_alu_sel !== 4'b0000) $display("FAIL unsup_alu_sel: got %b want 0000", s_alu_sel);
    else n_pass++;
    tick();
    n_total++;
    e = sb.pop_front();
    if (!hs0 || s_res !== '0 || s_err !== 1'b1 || e.res !== s_res || e.err !== s_err)
      $display("FAIL unsup_rsp: got hs=%b res=%h err=%b want 1 0 1", hs0, s_res, s_err);
    else n_pass++;
    set_req0(32'hF0, 32'h0F, 4'b0100);
    repeat (3) tick();
    n_total++;
    e = sb.pop_front();
    if (!hs0 || s_res !== 32'hFF || s_err !== 1'b0 || e.res !== s_res)
      $display("FAIL unsup_next: got hs=%b res=%h err=%b want 1 ff 0", hs0, s_res, s_err);
    else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    int served;
    logic seen;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    set_req0(32'h8000_0000, 32'd4, 4'b1010);
    tick();  // now in the execute cycle
    n_total++;
    if (alu_sel !== 4'b1010) $display("FAIL rst_mid_exec: got sel=%b want 1010", alu_sel);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (alu_a !== '0 || alu_b !== '0 || alu_sel !== 4'b0 || rsp_result !== '0 || rsp0_valid !== 1'b0)
      $display("FAIL rst_mid_zero: got a=%h sel=%b res=%h rv0=%b want zeros",
               alu_a, alu_sel, rsp_result, rsp0_valid);
    else n_pass++;
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      tick();
      seen = seen | s_rv0 | s_rv1;
    end
    n_total++;
    if (seen !== 1'b0) $display("FAIL rst_mid_no_rsp: got a response after reset");
    else n_pass++;
    set_req0(32'd8, 32'd1, 4'b1000);
    set_req1(32'd8, 32'd1, 4'b1001);
    tick();
    n_total++;
    if ({s_rdy0, s_rdy1} !== 2'b10) $display("FAIL rst_mid_tie: got %b want 10", {s_rdy0, s_rdy1});
    else n_pass++;
    served = 0;
    for (int i = 0; i < 16 && served < 2; i++) begin
      tick();
      if (hs0 || hs1) begin
        n_total++;
        e = sb.pop_front();
        if (e.id !== hs1 || e.res !== s_res || e.err !== s_err)
          $display("FAIL rst_mid_rsp: got id=%b res=%h want id=%b res=%h", hs1, s_res, e.id, e.res);
        else n_pass++;
        served++;
      end
    end
  endtask

  task automatic test_random();
    int served;
    served = 0;
    for (int i = 0; i < 300; i++) begin
      if (!req0_valid && ($urandom_range(0, 2) == 0))
        set_req0($urandom(), $urandom(), 4'($urandom_range(0, 15)));
      if (!req1_valid && ($urandom_range(0, 2) == 0))
        set_req1($urandom(), $urandom(), 4'($urandom_range(0, 15)));
      rsp0_ready = 1'($urandom_range(0, 1));
      rsp1_ready = 1'($urandom_range(0, 1));
      tick();
      if (hs0 || hs1) begin
        n_total++;
        if (sb.size() == 0) $display("FAIL rand_rsp: response with empty scoreboard");
        else begin
          e = sb.pop_front();
          if (e.id !== hs1 || e.res !== s_res || e.err !== s_err)
            $display("FAIL rand_rsp: got id=%b res=%h err=%b want id=%b res=%h err=%b",
                     hs1, s_res, s_err, e.id, e.res, e.err);
          else n_pass++;
        end
        served++;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int i = 0; i < 8 && sb.size() != 0; i++) begin
      tick();
      if (hs0 || hs1) begin
        n_total++;
        e = sb.pop_front();
        if (e.id !== hs1 || e.res !== s_res || e.err !== s_err)
          $display("FAIL rand_drain: got id=%b res=%h want id=%b res=%h", hs1, s_res, e.id, e.res);
        else n_pass++;
        served++;
      end
    end
    n_total++;
    if (sb.size() != 0 || served < 20)
      $display("FAIL rand_done: got pending=%0d served=%0d want 0 and >=20", sb.size(), served);
    else n_pass++;
  endtask

`ifdef ALU_ARB_STATS_EN
  task automatic test_stats();
    apply_reset();
    rsp1_ready = 1'b1;
    repeat (3) begin
      set_req1(32'd1, 32'd1, 4'b0000);
      repeat (3) tick();
      if (hs1) void'(sb.pop_front());
    end
    n_total++;
    if (gnt_cnt1 !== 16'd3 || gnt_cnt0 !== 16'd0)
      $display("FAIL stats_count: got cnt1=%0d cnt0=%0d want 3 0", gnt_cnt1, gnt_cnt0);
    else n_pass++;
    set_req1(32'd1, 32'd1, 4'b0000);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    n_total++;
    if (s_rdy1 !== 1'b1 || gnt_cnt1 !== 16'd0)
      $display("FAIL stats_clr: got rdy1=%b cnt1=%0d want 1 0", s_rdy1, gnt_cnt1);
    else n_pass++;
    repeat (2) tick();
    sb.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_unsupported();
    test_reset_mid_op();
    test_random();
`ifdef ALU_ARB_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU between two requesters, e.g. the main datapath (req0) and an auxiliary address/compare unit (req1).
- Round-robin arbitration with valid/ready request and response handshakes.
- Sequences one operation at a time: registers the operands, drives the ALU for one cycle, captures the result, and holds it until the winning requester accepts it.

Parameters:
XLEN, 32, operand/result width in bits

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  XLEN  operand A
req0_b  input  XLEN  operand B
req0_sel  input  4  ALUsel encoding
req1_valid, req1_ready, req1_a, req1_b, req1_sel  same as req0, for requester 1
rsp0_valid  output  1  result for requester 0 available
rsp0_ready  input  1  requester 0 takes result
rsp1_valid  output  1  result for requester 1 available
rsp1_ready  input  1  requester 1 takes result
rsp_result  output  XLEN  result, shared by both responses
rsp_err  output  1  operation had an unsupported sel
alu_a  output  XLEN  to ALU operand A
alu_b  output  XLEN  to ALU operand B
alu_sel  output  4  to ALU operation select
alu_result  input  XLEN  from ALU, combinational on alu_a/alu_b/alu_sel

Behaviour:
- Clock and reset: clk plus rst_n, asynchronous active-low reset. All outputs deassert immediately on reset assertion.
- Reset values:
  - state=IDLE; all ready/valid outputs 0.
  - rsp_result=0, rsp_err=0; alu_a=0, alu_b=0, alu_sel=4'b0000.
  - Round-robin pointer last=1, so req0 wins the first tie.
- Legal sel values: 0000 ADD, 0001 SUB, 0100 OR, 0101 AND, 0111 XOR, 1000 SLL, 1001 SRL, 1010 SRA, 1101 SLT, 1111 SLTU. Any other value is unsupported.
- IDLE state:
  - Only one valid: that requester wins.
  - Both valid: the requester not equal to last wins.
  - The winner's reqN_ready=1 combinationally in this cycle; the loser's ready=0.
  - On accept: latch a, b, sel and grant id; set last=id; go to EXEC.
  - No valid: stay in IDLE, both ready=0.
- EXEC state (1 cycle):
  - Drive alu_a/alu_b from the registered operands.
  - Drive alu_sel from the registered sel, or 4'b0000 if the sel is unsupported.
  - Capture alu_result into rsp_result. If the sel is unsupported, capture 0 instead and set rsp_err=1; otherwise rsp_err=0.
  - Go to RESP.
- Outside EXEC: alu_a/alu_b/alu_sel = 0/0/0000, so the ALU inputs are quiet.
- RESP state:
  - rspN_valid=1 only for the granted id; rsp_result and rsp_err are held stable.
  - When rspN_ready=1: go to IDLE and drop rspN_valid on the next cycle.
  - ready from the non-granted requester is ignored.
- Latency and throughput:
  - Accept at cycle T; EXEC at T+1; rsp valid from T+2.
  - Back-to-back throughput is 1 op per 3 cycles when rsp_ready is tied high.
- Ready rules:
  - No reqN_ready during EXEC or RESP; requests wait with valid held.
  - A requester deasserting valid before ready is legal and simply not served.
- Simultaneous events: an rsp accept and a new request in the same cycle are not merged. The new request is evaluated in the following IDLE cycle, using the updated last.
- Reset mid-operation: the in-flight op is discarded and no response is issued.
- Width rule: XLEN-bit pass-through, with no sign or width manipulation in this block.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- Defined:
  - Adds input stats_clr (1) and outputs gnt_cnt0 (16) and gnt_cnt1 (16).
  - gnt_cntN increments on each accept of requester N and saturates at 16'hFFFF.
  - stats_clr is a synchronous clear to 0 and has priority over the increment.
  - Both counters reset to 0.
- Undefined: the port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset then single op: req0 ADD a=5 b=7, rsp0_ready=1.
  -> req0_ready same cycle; alu_sel=0000 at T+1; rsp0_valid at T+2 with rsp_result=12, rsp_err=0.
- Tie: req0 SUB 10-3 and req1 XOR F0^0F both held valid, rsp ready high.
  -> req0 served first (7), then req1 (FF); next tie grants req0 again.
- Backpressure: req1 SLTU a=1 b=2, rsp1_ready low for 5 cycles.
  -> rsp1_valid=1 and result=1 held stable for all 5 cycles; req0 held valid is not readied until after the rsp1 handshake.
- Unsupported sel 4'b0010 from req0.
  -> alu_sel=0000 in EXEC; rsp_result=0, rsp_err=1; the next legal op returns rsp_err=0.
- rst_n pulled low during EXEC of an SRA op.
  -> outputs zero immediately, no rsp_valid; after release, a tie grants req0.
- ALU_ARB_STATS_EN defined: 3 req1 grants then stats_clr asserted together with a 4th grant.
  -> gnt_cnt1 = 3 before the clear, then 0.
  -> Preloaded at FFFF, the counter stays at FFFF on the next grant.
